timer_mc: RTL and testbench

//  Multi-channel programmable interval timer; parametrised successor to the single-channel tick timer.
//  NCH independent up-counters share one clock prescaler. Each counter runs from a start value to a

---
 rtl/timer_mc.sv | 73 +++++++
 tb/tb_timer_mc.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/timer_mc.sv
// timer_mc: multi-channel interval timer, NCH up-counters sharing one clock prescaler
module timer_mc #(
    parameter int NBITS = 32,
    parameter int NCH   = 4,
    parameter int PW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PW-1:0]        presc,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       oneshot,
    input  logic [NCH*NBITS-1:0] cnt_ini,
    input  logic [NCH*NBITS-1:0] cnt_rst,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       busy,
    output logic [NCH*NBITS-1:0] count
);
    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;
    logic [PW-1:0] pc;
    logic          strobe;
    // >= rather than == so lowering presc below pc ends the period at once
    assign strobe = pc >= presc;
    always_ff @(posedge clk or negedge reset)
        if (!reset) pc <= '0;
        else        pc <= strobe ? '0 : pc + 1'b1;
    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            logic             state;
            logic             tick_r;
            logic             sh_os;
            logic [NBITS-1:0] cnt;
            logic [NBITS-1:0] sh_ini;
            logic [NBITS-1:0] sh_rst;
            logic [NBITS-1:0] ini;
            logic [NBITS-1:0] trm;
            assign ini = cnt_ini[i*NBITS +: NBITS];
            assign trm = cnt_rst[i*NBITS +: NBITS];
            always_ff @(posedge clk or negedge reset)
                if (!reset) begin
                    state  <= IDLE;
                    tick_r <= 1'b0;
                    sh_os  <= 1'b0;
                    cnt    <= '0;
                    sh_ini <= '0;
                    sh_rst <= '0;
                end else if (!en[i]) begin
                    state  <= IDLE;
                    tick_r <= 1'b0;
                    cnt    <= ini;
                end else if (start[i]) begin
                    state  <= RUN;
                    tick_r <= 1'b0;
                    sh_os  <= oneshot[i];
                    sh_ini <= ini;
                    sh_rst <= trm;
                    cnt    <= ini;
                end else if (state == RUN && strobe && cnt == sh_rst) begin
                    state  <= sh_os ? IDLE : RUN;
                    tick_r <= 1'b1;
                    cnt    <= sh_ini;
                end else begin
                    tick_r <= 1'b0;
                    cnt    <= (state == RUN && strobe) ? cnt + 1'b1 : cnt;
                end
            assign tick[i]                = tick_r;
            assign busy[i]                = state == RUN;
            assign count[i*NBITS +: NBITS] = cnt;
        end
    endgenerate
endmodule

// File: tb/tb_timer_mc.sv
// tb_timer_mc: directed checks of timer_mc with 8-bit counters and 4 channels
module tb_timer_mc;
    logic        clk;
    logic        reset;
    logic [7:0]  presc;
    logic [3:0]  en;
    logic [3:0]  start;
    logic [3:0]  oneshot;
    logic [31:0] cnt_ini;
    logic [31:0] cnt_rst;
    logic [3:0]  tick;
    logic [3:0]  busy;
    logic [31:0] count;
    logic [7:0]  ini [4];
    logic [7:0]  trm [4];
    int          errors;
    int          checks;

    assign cnt_ini = {ini[3], ini[2], ini[1], ini[0]};
    assign cnt_rst = {trm[3], trm[2], trm[1], trm[0]};

    timer_mc #(.NBITS(8), .NCH(4), .PW(8)) dut (
        .clk(clk), .reset(reset), .presc(presc), .en(en), .start(start),
        .oneshot(oneshot), .cnt_ini(cnt_ini), .cnt_rst(cnt_rst),
        .tick(tick), .busy(busy), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt_of(input int c);
        return count[c*8 +: 8];
    endfunction

    task automatic run_periodic(input int c, input logic [7:0] base, input int n);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) step();
            chk($sformatf("ch%0d count k=%0d", c, k), cnt_of(c), 8'(base + k % 4));
            chk($sformatf("ch%0d tick k=%0d", c, k), tick[c], (k > 0 && k % 4 == 0));
            chk($sformatf("ch%0d busy k=%0d", c, k), busy[c], 1);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        presc   = 8'd0;
        en      = 4'h0;
        start   = 4'h0;
        oneshot = 4'h0;
        for (int c = 0; c < 4; c++) begin
            ini[c] = 8'h00;
            trm[c] = 8'h00;
        end
        step();
        step();
        chk("reset tick", tick, 0);
        chk("reset busy", busy, 0);
        chk("reset count", count, 0);
        reset = 1'b1;
        step();

        ini[0] = 8'h00; trm[0] = 8'h03; oneshot[0] = 1'b0; en[0] = 1'b1; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        run_periodic(0, 8'h00, 8);

        en[0] = 1'b0; ini[0] = 8'h55;
        step();
        chk("en drop busy", busy[0], 0);
        chk("en drop count", cnt_of(0), 8'h55);
        chk("en drop tick", tick[0], 0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("start ignored busy", busy[0], 0);
        chk("start ignored count", cnt_of(0), 8'h55);
        step();
        chk("start ignored tick", tick[0], 0);

        presc = 8'd4;
        ini[1] = 8'd10; trm[1] = 8'd12; oneshot[1] = 1'b1; en[1] = 1'b1; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        chk("os start busy", busy[1], 1);
        chk("os start count", cnt_of(1), 8'd10);
        repeat (13) step();
        chk("os pre count", cnt_of(1), 8'd12);
        chk("os pre tick", tick[1], 0);
        chk("os pre busy", busy[1], 1);
        step();
        chk("os tick", tick[1], 1);
        chk("os tick count", cnt_of(1), 8'd10);
        chk("os tick busy", busy[1], 0);
        step();
        chk("os after tick", tick[1], 0);
        chk("os after busy", busy[1], 0);
        chk("os after count", cnt_of(1), 8'd10);

        presc = 8'd0;
        ini[2] = 8'hFE; trm[2] = 8'h01; oneshot[2] = 1'b0; en[2] = 1'b1; start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        run_periodic(2, 8'hFE, 11);

        ini[2] = 8'h20; start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        chk("restart tick", tick[2], 0);
        chk("restart count", cnt_of(2), 8'h20);
        chk("restart busy", busy[2], 1);
        step();
        chk("restart next count", cnt_of(2), 8'h21);
        chk("restart next tick", tick[2], 0);

        #2;
        reset = 1'b0;
        #1;
        chk("async rst tick", tick, 0);
        chk("async rst busy", busy, 0);
        chk("async rst count", count, 0);
        step();
        chk("held rst count", count, 0);
        reset = 1'b1;
        repeat (6) begin
            step();
            chk("post rst tick", tick, 0);
            chk("post rst busy", busy, 0);
        end
        chk("post rst ch2 count", cnt_of(2), 8'h00);
        chk("post rst ch0 count", cnt_of(0), 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
